ex_wb_stage: RTL and testbench
==============================

# ex_wb_stage

Execute stage plus EX/WB pipeline register of the R-type MIPS pipeline: the consumer of the ID/EX register outputs. Each cycle it takes the registered ID/EX fields, resolves RAW hazards by forwarding from its own two most recent results, computes the ALU result and registers the write-back triple (data, address, enable) for the register file. It also keeps a free-running count of committed register writes for debug.

## Interface
- Parameters: none; data width fixed at 32, register address width fixed at 5.
- clk  in  1  pipeline clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ALUOp  in  2  from ID/EX; 00 add, 01 sub, 10 decode Funct, 11 reserved
- RegWrite  in  1  from ID/EX; instruction writes RdAddr
- RsData, RtData  in  32 each  operand values read in ID
- RsAddr, RtAddr  in  5 each  operand register numbers, carried through ID/EX for forwarding
- Funct  in  6  instruction funct field
- Shamt  in  5  shift amount
- RdAddr  in  5  destination register
- WriteData  out  32  registered ALU result to register file
- WriteAddr  out  5  registered destination
- WriteEn  out  1  registered write enable
- CommitCount  out  32  number of cycles in which WriteEn was 1, wrapping

## Operation
- Operand select (per operand, independently, Rs shown): if WriteEn=1, WriteAddr!=0 and WriteAddr==RsAddr, use WriteData (stage-1 forward); else if HistEn=1, HistAddr!=0 and HistAddr==RsAddr, use HistData (stage-2 forward); else RsData. Stage 1 has priority.
- History register (HistData/HistAddr/HistEn) loads the current WriteData/WriteAddr/WriteEn each cycle: covers the register file's read-before-write in ID.
- ALUOp 00: A+B; 01: A-B; 10 by Funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed, result 1/0), 0x00 sll (B<<Shamt), 0x02 srl (B>>Shamt logical). A=Rs operand, B=Rt operand.
- Add/sub wrap modulo 2^32; overflow ignored, no trap.
- ALUOp 11 or unrecognised Funct under 10: result 0 and write suppressed (next WriteEn=0).
- RdAddr 0: WriteEn still follows RegWrite; forwarding logic never selects address 0, so $zero stays 0 to consumers.
- Next WriteEn = RegWrite AND op valid; next WriteAddr = RdAddr; next WriteData = result.
- CommitCount increments by 1 on each rising edge where WriteEn is 1; 0xFFFFFFFF wraps to 0.

## Timing
- Latency: inputs sampled at edge N appear on WriteData/WriteAddr/WriteEn after edge N; history holds them after edge N+1.
- Back-to-back dependent instructions need no stall: instruction N+1 forwards from stage 1, N+2 from stage 2, N+3 reads the register file.
- Both forwarding sources matching the same address: stage 1 wins (youngest value).
- Rs and Rt both matching: both forwarded, shift ops use forwarded Rt.
- Reset (any time, asynchronous assert): WriteData=0, WriteAddr=0, WriteEn=0, History cleared to 0/0/0, CommitCount=0. Instruction in flight is dropped; no forwarding from pre-reset state after deassertion.
- No handshake; the block accepts one instruction per cycle unconditionally. Bubbles are ID/EX entries with RegWrite=0.

## Structure
- Shared package (mips_pkg): ALUOp codes, Funct codes (ADD, SUB, AND, OR, SLT, SLL, SRL), data and register-address widths.
- One combinational sub-module alu_rtype (operands, ALUOp, Funct, Shamt -> result, valid); forwarding muxes, pipeline/history registers and counter in ex_wb_stage.

## Test plan
- Reset mid-stream: assert rst_n=0 while WriteEn=1 -> all outputs 0 immediately, CommitCount=0; first post-reset instruction uses RsData/RtData unforwarded.
- Independent ops: add Rs=5,Rt=7,Rd=3 -> next cycle WriteData=12, WriteAddr=3, WriteEn=1; slt RsData=0xFFFFFFFF, RtData=1 -> 1; srl RtData=0x80000000, Shamt=31 -> 1.
- Stage-1 forward: add $3=2+3, then sub Rd=4 RsAddr=3 RsData=0 (stale), RtData=1 -> WriteData=4.
- Stage-2 and priority: writes $5=10, then $5=20, then add RsAddr=5 RtAddr=5 -> uses 20 (40); insert bubble between so only history matches -> uses history value.
- Zero register: instruction writing $0 with result 9, next reads RsAddr=0 RsData=0 -> operand 0, not 9.
- Invalid op and counter: ALUOp=10 Funct=0x3F RegWrite=1 -> WriteEn=0, CommitCount unchanged; preload-by-run counter to 0xFFFFFFFF then one commit -> 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the R-type MIPS pipeline: widths, ALUOp and Funct
// encodings, and the operand-forwarding selector used by the execute stage.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10,
    ALU_RSVD  = 2'b11
  } alu_op_e;

  typedef enum logic [5:0] {
    F_SLL = 6'h00,
    F_SRL = 6'h02,
    F_ADD = 6'h20,
    F_SUB = 6'h22,
    F_AND = 6'h24,
    F_OR  = 6'h25,
    F_SLT = 6'h2A
  } funct_e;

  // Youngest writer wins; register 0 is never forwarded so $zero reads as 0.
  function automatic logic [DATA_W-1:0] forward_sel(
    input logic [REG_AW-1:0] src_addr,
    input logic [DATA_W-1:0] src_data,
    input logic              s1_en,
    input logic [REG_AW-1:0] s1_addr,
    input logic [DATA_W-1:0] s1_data,
    input logic              s2_en,
    input logic [REG_AW-1:0] s2_addr,
    input logic [DATA_W-1:0] s2_data
  );
    if (s1_en && (s1_addr != '0) && (s1_addr == src_addr)) return s1_data;
    else if (s2_en && (s2_addr != '0) && (s2_addr == src_addr)) return s2_data;
    else return src_data;
  endfunction

endpackage

// File: rtl/alu_rtype.sv
// Combinational R-type ALU: add/sub by ALUOp, otherwise decoded from Funct.
// o_valid drops for the reserved ALUOp and for unrecognised Funct codes.
module alu_rtype
  import mips_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [1:0]        i_alu_op,
  input  logic [5:0]        i_funct,
  input  logic [4:0]        i_shamt,
  output logic [DATA_W-1:0] o_result,
  output logic              o_valid
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    o_result = '0;
    o_valid  = 1'b1;
    case (i_alu_op)
      ALU_ADD: o_result = i_a + i_b;
      ALU_SUB: o_result = i_a - i_b;
      ALU_FUNCT: begin
        case (i_funct)
          F_ADD:   o_result = i_a + i_b;
          F_SUB:   o_result = i_a - i_b;
          F_AND:   o_result = i_a & i_b;
          F_OR:    o_result = i_a | i_b;
          F_SLT:   o_result = ($signed(i_a) < $signed(i_b)) ? DATA_W'(1) : '0;
          F_SLL:   o_result = i_b << i_shamt;
          F_SRL:   o_result = i_b >> i_shamt;
          default: o_valid  = 1'b0;
        endcase
      end
      default: o_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_wb_stage.sv
// Execute stage plus EX/WB register: forwards from the two most recent
// results, runs the ALU, registers the write-back triple and counts commits.
module ex_wb_stage
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        ALUOp,
  input  logic              RegWrite,
  input  logic [DATA_W-1:0] RsData,
  input  logic [DATA_W-1:0] RtData,
  input  logic [REG_AW-1:0] RsAddr,
  input  logic [REG_AW-1:0] RtAddr,
  input  logic [5:0]        Funct,
  input  logic [4:0]        Shamt,
  input  logic [REG_AW-1:0] RdAddr,
  output logic [DATA_W-1:0] WriteData,
  output logic [REG_AW-1:0] WriteAddr,
  output logic              WriteEn,
  output logic [31:0]       CommitCount
);

  logic [DATA_W-1:0] r_write_data;
  logic [REG_AW-1:0] r_write_addr;
  logic              r_write_en;
  logic [DATA_W-1:0] r_hist_data;
  logic [REG_AW-1:0] r_hist_addr;
  logic              r_hist_en;
  logic [31:0]       r_commit_count;

  logic [DATA_W-1:0] w_op_a;
  logic [DATA_W-1:0] w_op_b;
  logic [DATA_W-1:0] w_result;
  logic              w_valid;

  assign w_op_a = forward_sel(RsAddr, RsData, r_write_en, r_write_addr, r_write_data,
                              r_hist_en, r_hist_addr, r_hist_data);
  assign w_op_b = forward_sel(RtAddr, RtData, r_write_en, r_write_addr, r_write_data,
                              r_hist_en, r_hist_addr, r_hist_data);

  alu_rtype u_alu (
    .i_a      (w_op_a),
    .i_b      (w_op_b),
    .i_alu_op (ALUOp),
    .i_funct  (Funct),
    .i_shamt  (Shamt),
    .o_result (w_result),
    .o_valid  (w_valid)
  );

  // History trails the write-back register by one cycle, covering the
  // register file's read-before-write in ID.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write_data   <= '0;
      r_write_addr   <= '0;
      r_write_en     <= 1'b0;
      r_hist_data    <= '0;
      r_hist_addr    <= '0;
      r_hist_en      <= 1'b0;
      r_commit_count <= '0;
    end else begin
      // NOTE: non-blocking assignments so history captures the pre-edge
      // write-back values rather than the ones being loaded this edge.
      r_write_data <= w_result;
      r_write_addr <= RdAddr;
      r_write_en   <= RegWrite & w_valid;
      r_hist_data  <= r_write_data;
      r_hist_addr  <= r_write_addr;
      r_hist_en    <= r_write_en;
      if (r_write_en) r_commit_count <= r_commit_count + 32'd1;
    end
  end

  assign WriteData   = r_write_data;
  assign WriteAddr   = r_write_addr;
  assign WriteEn     = r_write_en;
  assign CommitCount = r_commit_count;

endmodule

// File: tb/tb_ex_wb_stage.sv
// Self-checking bench for ex_wb_stage: a table of consecutive instructions with
// hand-computed write-back results, then an asynchronous mid-stream reset.
module tb_ex_wb_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  ALUOp;
  logic        RegWrite;
  logic [31:0] RsData, RtData;
  logic [4:0]  RsAddr, RtAddr, Shamt, RdAddr;
  logic [5:0]  Funct;
  logic [31:0] WriteData;
  logic [4:0]  WriteAddr;
  logic        WriteEn;
  logic [31:0] CommitCount;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_wb_stage dut (
    .clk(clk), .rst_n(rst_n), .ALUOp(ALUOp), .RegWrite(RegWrite),
    .RsData(RsData), .RtData(RtData), .RsAddr(RsAddr), .RtAddr(RtAddr),
    .Funct(Funct), .Shamt(Shamt), .RdAddr(RdAddr),
    .WriteData(WriteData), .WriteAddr(WriteAddr), .WriteEn(WriteEn),
    .CommitCount(CommitCount)
  );

  typedef struct {
    logic [1:0]  op;
    logic        rw;
    logic [4:0]  rs_a;
    logic [31:0] rs_d;
    logic [4:0]  rt_a;
    logic [31:0] rt_d;
    logic [5:0]  fn;
    logic [4:0]  sh;
    logic [4:0]  rd;
    logic [31:0] exp_data;
    logic        exp_en;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic rw,
                              input logic [4:0] rs_a, input logic [31:0] rs_d,
                              input logic [4:0] rt_a, input logic [31:0] rt_d,
                              input logic [5:0] fn, input logic [4:0] sh,
                              input logic [4:0] rd, input logic [31:0] exp_data,
                              input logic exp_en);
    vec_t v;
    v.op = op; v.rw = rw; v.rs_a = rs_a; v.rs_d = rs_d; v.rt_a = rt_a; v.rt_d = rt_d;
    v.fn = fn; v.sh = sh; v.rd = rd; v.exp_data = exp_data; v.exp_en = exp_en;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    ALUOp = v.op; RegWrite = v.rw; RsAddr = v.rs_a; RsData = v.rs_d;
    RtAddr = v.rt_a; RtData = v.rt_d; Funct = v.fn; Shamt = v.sh; RdAddr = v.rd;
  endtask

  initial begin
    int exp_count;
    logic prev_en;
    vec_t v;

    //        op  rw  rsA rsD           rtA rtD           fn     sh  rd  expData       en
    vecs[0]  = mk(2'b00, 1, 1,  32'd5,        2,  32'd7,        6'h00, 0,  3,  32'd12,       1); // add
    vecs[1]  = mk(2'b10, 1, 8,  32'hFFFFFFFF, 9,  32'd1,        6'h2A, 0,  10, 32'd1,        1); // slt -1<1
    vecs[2]  = mk(2'b10, 1, 12, 32'd0,        11, 32'h80000000, 6'h02, 31, 12, 32'd1,        1); // srl 31
    vecs[3]  = mk(2'b00, 1, 13, 32'd2,        14, 32'd3,        6'h00, 0,  3,  32'd5,        1); // $3=5
    vecs[4]  = mk(2'b01, 1, 3,  32'd0,        15, 32'd1,        6'h00, 0,  4,  32'd4,        1); // stage-1 fwd
    vecs[5]  = mk(2'b00, 1, 16, 32'd4,        17, 32'd6,        6'h00, 0,  5,  32'd10,       1); // $5=10
    vecs[6]  = mk(2'b00, 1, 18, 32'd15,       19, 32'd5,        6'h00, 0,  5,  32'd20,       1); // $5=20
    vecs[7]  = mk(2'b00, 1, 5,  32'd0,        5,  32'd0,        6'h00, 0,  6,  32'd40,       1); // priority
    vecs[8]  = mk(2'b00, 1, 20, 32'd60,       21, 32'd40,       6'h00, 0,  7,  32'd100,      1); // $7=100
    vecs[9]  = mk(2'b00, 0, 22, 32'd1,        23, 32'd1,        6'h00, 0,  8,  32'd2,        0); // bubble
    vecs[10] = mk(2'b00, 1, 7,  32'd0,        8,  32'd1,        6'h00, 0,  9,  32'd101,      1); // stage-2 only
    vecs[11] = mk(2'b00, 1, 25, 32'd4,        26, 32'd5,        6'h00, 0,  0,  32'd9,        1); // write $0
    vecs[12] = mk(2'b00, 1, 0,  32'd0,        27, 32'd3,        6'h00, 0,  13, 32'd3,        1); // read $0
    vecs[13] = mk(2'b10, 1, 28, 32'd1,        29, 32'd1,        6'h3F, 0,  14, 32'd0,        0); // bad funct
    vecs[14] = mk(2'b11, 1, 28, 32'd1,        29, 32'd1,        6'h20, 0,  15, 32'd0,        0); // rsvd op
    vecs[15] = mk(2'b10, 1, 30, 32'h0000F0F0, 31, 32'h00000FF0, 6'h24, 0,  16, 32'h000000F0, 1); // and
    vecs[16] = mk(2'b10, 1, 1,  32'h0000F000, 2,  32'h0000000F, 6'h25, 0,  17, 32'h0000F00F, 1); // or
    vecs[17] = mk(2'b10, 1, 2,  32'd0,        17, 32'd0,        6'h00, 4,  18, 32'h000F00F0, 1); // sll fwd Rt
    vecs[18] = mk(2'b10, 1, 18, 32'd0,        18, 32'd0,        6'h20, 0,  19, 32'h001E01E0, 1); // both fwd
    vecs[19] = mk(2'b10, 1, 30, 32'd5,        31, 32'd7,        6'h22, 0,  20, 32'hFFFFFFFE, 1); // sub wrap
    vecs[20] = mk(2'b10, 1, 21, 32'd1,        22, 32'hFFFFFFFF, 6'h2A, 0,  21, 32'd0,        1); // slt 1<-1

    rst_n = 1'b0;
    drive(mk(2'b00, 0, 0, 0, 0, 0, 6'h00, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    check("reset_data", WriteData, 32'd0);
    check("reset_addr", {27'd0, WriteAddr}, 32'd0);
    check("reset_en", {31'd0, WriteEn}, 32'd0);
    check("reset_count", CommitCount, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    exp_count = 0;
    prev_en   = 1'b0;
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      @(posedge clk);
      if (prev_en) exp_count++;
      #1;
      check($sformatf("v%0d_data", i), WriteData, vecs[i].exp_data);
      check($sformatf("v%0d_addr", i), {27'd0, WriteAddr}, {27'd0, vecs[i].rd});
      check($sformatf("v%0d_en", i), {31'd0, WriteEn}, {31'd0, vecs[i].exp_en});
      check($sformatf("v%0d_count", i), CommitCount, exp_count);
      prev_en = vecs[i].exp_en;
    end

    // Asynchronous reset while WriteEn=1, away from any clock edge.
    @(negedge clk);
    drive(mk(2'b00, 1, 21, 32'd3, 22, 32'd4, 6'h00, 0, 5, 32'd7, 1));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_data", WriteData, 32'd0);
    check("async_rst_en", {31'd0, WriteEn}, 32'd0);
    check("async_rst_count", CommitCount, 32'd0);
    @(posedge clk);
    #1;
    check("rst_hold_en", {31'd0, WriteEn}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // First post-reset instruction names the pre-reset WriteAddr; must not forward.
    v = mk(2'b00, 1, 21, 32'd3, 20, 32'd4, 6'h00, 0, 5, 32'd7, 1);
    drive(v);
    @(posedge clk);
    #1;
    check("post_rst_data", WriteData, 32'd7);
    check("post_rst_en", {31'd0, WriteEn}, 32'd1);
    check("post_rst_count0", CommitCount, 32'd0);
    @(negedge clk);
    drive(mk(2'b00, 0, 0, 0, 0, 0, 6'h00, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    check("post_rst_count1", CommitCount, 32'd1);
    @(posedge clk);
    #1;
    check("post_rst_count_hold", CommitCount, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
